// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous-read instruction memory.
package imem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } imem_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Legal means word aligned and the word index falls inside the array.
    function automatic logic addr_legal(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
    endfunction

endpackage

// File: rtl/imem_init_ctrl.sv
// Post-reset clear sweep: walks every word index once, then hands the memory to the fetch/load ports.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | sweep in progress, one word written per cycle, ports blocked
// READY | sweep done, fetch and load ports live
module imem_init_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             init_busy,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx
);

    localparam logic [0:0]       ST_CLEAR = 1'(CLEAR);
    localparam logic [0:0]       ST_READY = 1'(READY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] cnt;

    // The counter stops at the last index rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (cnt == LAST_IDX) begin
                        state <= ST_READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end

    assign init_busy = (state == ST_CLEAR);
    assign clr_we    = (state == ST_CLEAR);
    assign clr_idx   = cnt;

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with byte-addressed fetch port, program-load port and reset clear sweep.
module instr_mem_sync
    import imem_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     DEPTH      = 64,
    parameter int unsigned     ADDR_W     = 32,
    parameter logic [XLEN-1:0] CLEAR_WORD = XLEN'(NOP)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [XLEN-1:0]   rd_data,
    output logic              rd_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;
    logic             rd_legal;
    logic             ld_legal;
    logic             rd_accept;
    logic             ld_accept;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] ld_idx;

    imem_init_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_init_ctrl (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_idx   (clr_idx)
    );

    assign rd_ready  = !init_busy;
    assign rd_legal  = addr_legal(64'(rd_addr), DEPTH);
    assign ld_legal  = addr_legal(64'(ld_addr), DEPTH);
    assign rd_idx    = rd_addr[2 +: IDX_W];
    assign ld_idx    = ld_addr[2 +: IDX_W];
    assign rd_accept = rd_req && rd_ready;
    assign ld_accept = ld_en && !init_busy && ld_legal;

    // No reset on the array: only the sweep and the load port ever change it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= CLEAR_WORD;
        end else if (ld_accept) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Reading mem here with non-blocking writes gives read-before-write on a shared edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_fault <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_fault <= !rd_legal;
                rd_data  <= rd_legal ? mem[rd_idx] : CLEAR_WORD;
            end
            ld_err <= ld_en && (init_busy || !ld_legal);
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync against a word-array reference model.
module tb_instr_mem_sync;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_busy;
    logic        rd_req = 1'b0;
    logic        rd_ready;
    logic [31:0] rd_addr = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_fault;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    instr_mem_sync #(
        .XLEN       (32),
        .DEPTH      (DEPTH),
        .ADDR_W     (32),
        .CLEAR_WORD (NOP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .rd_req    (rd_req),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_fault  (rd_fault),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_err    (ld_err)
    );

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    function automatic logic [31:0] gen_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r < 9) return 32'($urandom_range(0, 4 * DEPTH + 15));
        else return $urandom;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        rd_req = 1'b1;
        rd_addr = a;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Counts cycles from reset release until init_busy drops; rd_ready must stay low meanwhile.
    task automatic measure_sweep(input string name);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 200) begin
            checks++;
            if (rd_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_rd_ready_low cycle=%0d got=%b exp=0", name, n, rd_ready);
            end
            tick();
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL %s_sweep_len got=%0d exp=%0d", name, n, DEPTH);
        end
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_rd_ready_after got=%b exp=1", name, rd_ready);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = NOP_W;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({init_busy, rd_valid, rd_fault, ld_err} !== 4'b1000 || rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got busy=%b valid=%b fault=%b err=%b data=%h exp 1 0 0 0 00000000",
                     init_busy, rd_valid, rd_fault, ld_err, rd_data);
        end
        reset = 1'b0;
        measure_sweep("reset");
    endtask

    task automatic test_clear_fetch();
        logic [31:0] addrs [2];
        addrs[0] = 32'h000;
        addrs[1] = 32'h0FC;
        for (int i = 0; i < 2; i++) begin
            fetch(addrs[i]);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== NOP_W || rd_fault !== 1'b0) begin
                failures++;
                $display("FAIL clear_fetch addr=%h got v=%b d=%h f=%b exp v=1 d=%h f=0",
                         addrs[i], rd_valid, rd_data, rd_fault, NOP_W);
            end
        end
    endtask

    task automatic test_load_fetch();
        load(32'h008, 32'h0050_0093);
        checks++;
        if (ld_err !== 1'b0) begin
            failures++;
            $display("FAIL load_legal_err got=%b exp=0", ld_err);
        end
        model[2] = 32'h0050_0093;
        fetch(32'h008);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0050_0093 || rd_fault !== 1'b0) begin
            failures++;
            $display("FAIL load_fetch got v=%b d=%h f=%b exp v=1 d=00500093 f=0", rd_valid, rd_data, rd_fault);
        end
    endtask

    task automatic test_faults();
        fetch(32'h006);
        checks++;
        if (rd_valid !== 1'b1 || rd_fault !== 1'b1 || rd_data !== NOP_W) begin
            failures++;
            $display("FAIL misaligned_fetch got v=%b d=%h f=%b exp v=1 d=%h f=1", rd_valid, rd_data, rd_fault, NOP_W);
        end
        fetch(32'h008);
        fetch(32'h100);
        checks++;
        if (rd_valid !== 1'b1 || rd_fault !== 1'b1 || rd_data !== NOP_W) begin
            failures++;
            $display("FAIL range_fetch got v=%b d=%h f=%b exp v=1 d=%h f=1", rd_valid, rd_data, rd_fault, NOP_W);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_fault !== 1'b1 || rd_data !== NOP_W) begin
            failures++;
            $display("FAIL idle_hold got v=%b d=%h f=%b exp v=0 d=%h f=1", rd_valid, rd_data, rd_fault, NOP_W);
        end
        load(32'h102, 32'h1111_2222);
        checks++;
        if (ld_err !== 1'b1) begin
            failures++;
            $display("FAIL load_range_err got=%b exp=1", ld_err);
        end
        tick();
        checks++;
        if (ld_err !== 1'b0) begin
            failures++;
            $display("FAIL ld_err_pulse got=%b exp=0", ld_err);
        end
    endtask

    task automatic test_same_edge();
        rd_req = 1'b1;
        rd_addr = 32'h010;
        ld_en = 1'b1;
        ld_addr = 32'h010;
        ld_data = 32'hDEAD_BEEF;
        tick();
        ld_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== model[4]) begin
            failures++;
            $display("FAIL same_edge_old got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, model[4]);
        end
        model[4] = 32'hDEAD_BEEF;
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL same_edge_new got v=%b d=%h exp v=1 d=deadbeef", rd_valid, rd_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_data;
        logic        exp_fault;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] la;
        logic [31:0] ldv;
        logic        le;
        exp_data = rd_data;
        exp_fault = rd_fault;
        for (int c = 0; c < 400; c++) begin
            rd_req = 1'($urandom_range(0, 1));
            rd_addr = gen_addr();
            le = ($urandom_range(0, 3) == 0);
            la = gen_addr();
            ldv = $urandom;
            ld_en = le;
            ld_addr = la;
            ld_data = ldv;
            exp_valid = rd_req;
            if (rd_req) begin
                exp_fault = !legal(rd_addr);
                exp_data = legal(rd_addr) ? model[rd_addr / 4] : NOP_W;
            end
            exp_err = le && !legal(la);
            tick();
            if (le && legal(la)) model[la / 4] = ldv;
            checks++;
            if (rd_valid !== exp_valid || rd_data !== exp_data || rd_fault !== exp_fault || ld_err !== exp_err) begin
                failures++;
                $display("FAIL random c=%0d got v=%b d=%h f=%b e=%b exp v=%b d=%h f=%b e=%b",
                         c, rd_valid, rd_data, rd_fault, ld_err, exp_valid, exp_data, exp_fault, exp_err);
            end
        end
        rd_req = 1'b0;
        ld_en = 1'b0;
    endtask

    task automatic test_back_to_back(input string name);
        rd_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = 32'(i * 4);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== model[i] || rd_fault !== 1'b0) begin
                failures++;
                $display("FAIL %s_scan idx=%0d got v=%b d=%h f=%b exp v=1 d=%h f=0",
                         name, i, rd_valid, rd_data, rd_fault, model[i]);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        load(32'h004, 32'h1234_5678);
        model[1] = 32'h1234_5678;
        fetch(32'h004);
        checks++;
        if (rd_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL pre_reset_load got=%h exp=12345678", rd_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        measure_sweep("midreset");
        fetch(32'h004);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== NOP_W) begin
            failures++;
            $display("FAIL midreset_word1 got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, NOP_W);
        end
    endtask

    task automatic test_sweep_inputs();
        int n;
        reset = 1'b1;
        rd_req = 1'b1;
        rd_addr = 32'h000;
        ld_en = 1'b1;
        ld_addr = 32'h020;
        ld_data = 32'hCAFE_F00D;
        tick();
        reset = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 200) begin
            tick();
            n++;
            checks++;
            if (rd_valid !== 1'b0 || ld_err !== 1'b1) begin
                failures++;
                $display("FAIL sweep_inputs cycle=%0d got v=%b e=%b exp v=0 e=1", n, rd_valid, ld_err);
            end
        end
        rd_req = 1'b0;
        ld_en = 1'b0;
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL sweep_inputs_len got=%0d exp=%0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = NOP_W;
        test_back_to_back("sweep_inputs");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        test_reset();
        test_clear_fetch();
        test_load_fetch();
        test_faults();
        test_same_edge();
        test_random();
        test_back_to_back("post_random");
        test_reset_mid_sweep();
        test_sweep_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous-read instruction memory for the single-cycle RISC-V core, replacing the fixed 64-word store in front of the program counter.
- Byte-addressed fetch port with request/valid handshake.
- Program-load write port for the testbench or boot loader.
- Alignment and range fault reporting.
- After reset, a multi-cycle sweep fills every word with a configurable clear value (NOP by default) instead of a one-cycle bulk reset.

## Interface
- XLEN, 32, instruction/data word width in bits
- DEPTH, 64, number of words (≥2, any value)
- ADDR_W, 32, byte-address width
- CLEAR_WORD, 32'h0000_0013, value written to every word by the reset sweep (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- init_busy  out  1  clear sweep in progress
- rd_req  in  1  fetch request
- rd_ready  out  1  fetch port can accept (= !init_busy)
- rd_addr  in  ADDR_W  fetch byte address
- rd_valid  out  1  one-cycle pulse, result of accepted fetch
- rd_data  out  XLEN  fetched word, held until next accepted fetch
- rd_fault  out  1  accompanies rd_valid; address misaligned or out of range
- ld_en  in  1  program-load write strobe
- ld_addr  in  ADDR_W  load byte address
- ld_data  in  XLEN  load word
- ld_err  out  1  one-cycle pulse, load rejected

## Operation
- Word index is rd_addr[ADDR_W-1:2], and likewise ld_addr[ADDR_W-1:2]. The address is legal only if addr[1:0]==0 and index < DEPTH.
- FSM states are CLEAR and READY.
- **Reset** forces CLEAR and sets the sweep counter to 0. Reset values:
  - init_busy=1, rd_valid=0, rd_data=0, rd_fault=0, ld_err=0.
  - Memory contents are not touched by reset itself.
- **CLEAR:**
  - Each cycle writes CLEAR_WORD to mem[counter], then increments the counter.
  - After the write of index DEPTH-1, the FSM goes to READY.
  - Reset asserted at any point restarts the sweep from index 0.
- **READY:** a fetch is accepted on an edge where rd_req && rd_ready.
  - Legal address: next cycle rd_valid=1, rd_data=mem[index], rd_fault=0.
  - Illegal address: next cycle rd_valid=1, rd_fault=1, rd_data=CLEAR_WORD.
  - No accepted fetch: rd_valid=0 next cycle, and rd_data/rd_fault hold their values.
- **Load:** on an edge with ld_en:
  - If READY and the address is legal, mem[index] <= ld_data.
  - Otherwise (CLEAR state or illegal address) memory is unchanged and ld_err=1 next cycle.
- **Simultaneous load and fetch of the same word:** the fetch returns the old contents (read-before-write). A fetch accepted on the following edge returns the new word.
- rd_req and ld_en are ignored entirely while init_busy=1. No fetch is queued.

## Timing
- Fetch latency is 1 cycle, request edge to rd_valid. Throughput is one fetch per cycle, back-to-back.
- The sweep lasts exactly DEPTH cycles after reset deasserts:
  - init_busy falls on the edge that writes index DEPTH-1.
  - rd_ready=1 from the next cycle.
- Load write latency is 1 edge. ld_err pulses 1 cycle after the rejected edge.
- All outputs are registered except rd_ready, which is combinational from state.
- The sweep counter is $clog2(DEPTH) bits with no wrap. The transition to READY happens at DEPTH-1.

## Structure
- Package imem_pkg contains:
  - state enum {CLEAR, READY}
  - NOP constant 32'h0000_0013
  - helper function for the legal-address check (alignment + range)
- One natural sub-module, imem_init_ctrl:
  - Contains the FSM and sweep counter.
  - Outputs: init_busy, clear write enable, clear index.
- The top level holds the memory array, write-port mux (clear vs load), and fetch output registers.

## Test plan
- Reset release, DEPTH=64: init_busy high for exactly 64 cycles and rd_ready low throughout. Then fetching 0x000, 0x0FC returns 0x00000013 with rd_fault=0.
- Load 0x00500093 @0x008, then fetch 0x008 next cycle: rd_valid=1 one cycle later, rd_data=0x00500093.
- Fetch 0x006 returns rd_fault=1, rd_data=0x13. Fetch 0x100 (DEPTH=64) returns rd_fault=1. Load to 0x102 gives ld_err=1 and memory unchanged.
- Same edge: load 0xDEADBEEF @0x010 and fetch 0x010 returns the old 0x13. Fetching 0x010 on the next edge returns 0xDEADBEEF.
- Reset asserted at sweep cycle 20: init_busy stays high another 64 cycles after release, and a prior load to 0x004 reads back 0x13.
- rd_req and ld_en held high during the sweep: no rd_valid pulses, ld_err pulses each cycle, and memory stays all 0x13.
